key_debounce: RTL



---
 rtl/key_debounce_pkg.sv | 17 +
 rtl/key_debounce_if.sv | 25 ++
 rtl/key_debounce_cell.sv | 105 ++++++++++
 rtl/key_debounce.sv | 51 +++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared definitions for the pushbutton debouncer: channel FSM encodings and
// the mapping from channel state to the active-low debounced level.
package key_debounce_pkg;

  typedef logic [1:0] key_state_t;

  localparam key_state_t ST_UP        = 2'b00;
  localparam key_state_t ST_WAIT_DOWN = 2'b01;
  localparam key_state_t ST_DOWN      = 2'b10;
  localparam key_state_t ST_WAIT_UP   = 2'b11;

  // Key reads pressed (0) in DOWN and WAIT_UP, released (1) otherwise.
  function automatic logic key_level(input key_state_t st);
    return ~st[1];
  endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Key-side bundle of the debouncer: raw keys in, debounced levels, pulses,
// sticky capture and per-channel FSM state (2 bits per key) for debug.
interface key_debounce_if #(
  parameter int NUM_KEYS = 3
);
  // Pulses are single-cycle and aligned to the first cycle key_n_out shows
  // the new level; capture_clr is sampled on every clock, no handshake.
  logic [NUM_KEYS-1:0]   key_n_in;
  logic [NUM_KEYS-1:0]   capture_clr;
  logic [NUM_KEYS-1:0]   key_n_out;
  logic [NUM_KEYS-1:0]   press_pulse;
  logic [NUM_KEYS-1:0]   release_pulse;
  logic [NUM_KEYS-1:0]   capture;
  logic [2*NUM_KEYS-1:0] dbg_state;

  modport master (
    output key_n_in, capture_clr,
    input  key_n_out, press_pulse, release_pulse, capture, dbg_state
  );

  modport slave (
    input  key_n_in, capture_clr,
    output key_n_out, press_pulse, release_pulse, capture, dbg_state
  );
endinterface

// File: rtl/key_debounce_cell.sv
// One debounce channel: 2-flop synchronizer, stability counter, four-state
// FSM and registered level / press / release outputs.
module key_debounce_cell
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 24
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_n_raw,
  output logic       key_n_out,
  output logic       press_pulse,
  output logic       release_pulse,
  output key_state_t state_dbg
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync_1;
  logic             sync_2;
  key_state_t       state;
  key_state_t       state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= key_n_raw;
      sync_2 <= sync_1;
    end
  end

  // Any reversal while waiting drops back to the stable state with cnt=0,
  // so a glitch shorter than DEBOUNCE_CYCLES never reaches the output.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_UP: begin
        if (!sync_2) begin
          state_nx = ST_WAIT_DOWN;
          cnt_nx   = CNT_ONE;
        end
      end
      ST_WAIT_DOWN: begin
        if (sync_2) begin
          state_nx = ST_UP;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = ST_DOWN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      ST_DOWN: begin
        if (sync_2) begin
          state_nx = ST_WAIT_UP;
          cnt_nx   = CNT_ONE;
        end
      end
      ST_WAIT_UP: begin
        if (!sync_2) begin
          state_nx = ST_DOWN;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = ST_UP;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nx = ST_UP;
        cnt_nx   = '0;
      end
    endcase
  end

  // Level and pulses are registered from the next state so they change on
  // the same edge as the FSM commits the transition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_UP;
      cnt           <= '0;
      key_n_out     <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      key_n_out     <= key_level(state_nx);
      press_pulse   <= (state == ST_WAIT_DOWN) && (state_nx == ST_DOWN);
      release_pulse <= (state == ST_WAIT_UP) && (state_nx == ST_UP);
    end
  end

  assign state_dbg = state;

endmodule

// File: rtl/key_debounce.sv
// Debouncer for the active-low KEY[3:1] pushbuttons feeding keys_export:
// NUM_KEYS independent channels plus a sticky press-capture register.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 24
) (
  input  logic           clk,
  input  logic           reset_n,
  key_debounce_if.slave  bus
);

  logic [NUM_KEYS-1:0]   key_n_out_v;
  logic [NUM_KEYS-1:0]   press_v;
  logic [NUM_KEYS-1:0]   release_v;
  logic [NUM_KEYS-1:0]   capture_q;
  logic [2*NUM_KEYS-1:0] dbg_v;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_cell
    key_debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_cell (
      .clk           (clk),
      .reset_n       (reset_n),
      .key_n_raw     (bus.key_n_in[i]),
      .key_n_out     (key_n_out_v[i]),
      .press_pulse   (press_v[i]),
      .release_pulse (release_v[i]),
      .state_dbg     (dbg_v[2*i +: 2])
    );
  end

  // Set has priority: a press in the same cycle as a clear stays captured.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      capture_q <= '0;
    end else begin
      capture_q <= (capture_q & ~bus.capture_clr) | press_v;
    end
  end

  assign bus.key_n_out     = key_n_out_v;
  assign bus.press_pulse   = press_v;
  assign bus.release_pulse = release_v;
  assign bus.capture       = capture_q;
  assign bus.dbg_state     = dbg_v;

endmodule
